ex_mem_pipe: RTL and testbench

- Parametrised EX/MEM pipeline stage register.
- Adds the following to a plain EX→MEM register:
  - stall handling: hold and bubble insertion from the pipeline controller
  - flush
  - HI/LO write transport
  - a valid bit
  - feedback storage for multi-cycle EX ops (madd/msub: partial product + cycle count), held while EX iterates.
- Sits between the ex and mem stages. Also feeds hilo_o/cnt_o back to ex.

---
 rtl/ex_mem_pipe.sv | 97 +++++++++
 tb/tb_ex_mem_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: stall hold/bubble, flush, HI/LO transport, multi-cycle scratch feedback.
// Optional perf counters when EX_MEM_PIPE_PERF_EN is defined; otherwise perf_* are tied to 0.
module ex_mem_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [31:0]           perf_bubble,
  output logic [31:0]           perf_hold,
  output logic [31:0]           perf_flush
);

  logic do_bubble;
  logic do_hold;

  assign do_bubble = stall_ex && !stall_mem;
  assign do_hold   = stall_mem;

  always_ff @(posedge clk) begin
    if (rst || flush || do_bubble) begin
      mem_valid <= 1'b0;
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
    end else if (!do_hold) begin
      // Invalid instructions still carry their fields but must not write anything.
      mem_valid <= ex_valid;
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg && ex_valid;
      mem_wdata <= ex_wdata;
      mem_whilo <= ex_whilo && ex_valid;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
    end
  end

  // Scratch survives only while EX iterates (bubble) or the stage is frozen (hold).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end else if (do_bubble) begin
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else if (!do_hold) begin
      hilo_o <= '0;
      cnt_o  <= '0;
    end
  end

`ifdef EX_MEM_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble <= '0;
      perf_hold   <= '0;
      perf_flush  <= '0;
    end else if (flush) begin
      if (perf_flush != 32'hFFFF_FFFF) perf_flush <= perf_flush + 32'd1;
    end else if (do_bubble) begin
      if (perf_bubble != 32'hFFFF_FFFF) perf_bubble <= perf_bubble + 32'd1;
    end else if (do_hold) begin
      if (perf_hold != 32'hFFFF_FFFF) perf_hold <= perf_hold + 32'd1;
    end
  end
`else
  assign perf_bubble = '0;
  assign perf_hold   = '0;
  assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe; perf expectations follow EX_MEM_PIPE_PERF_EN.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        rst, stall_ex, stall_mem, flush;
  logic        ex_valid, ex_wreg, ex_whilo;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic        mem_valid, mem_wreg, mem_whilo;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic [31:0] perf_bubble, perf_hold, perf_flush;

  int total = 0;
  int bad   = 0;
  int exp_bubble = 0, exp_hold = 0, exp_flush = 0;

`ifdef EX_MEM_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .perf_bubble(perf_bubble), .perf_hold(perf_hold), .perf_flush(perf_flush)
  );

  // Apply controls for one edge, sample 1 time unit after it, and advance the counter model.
  task automatic cycle(input logic r, input logic f, input logic se, input logic sm);
    rst = r; flush = f; stall_ex = se; stall_mem = sm;
    @(posedge clk);
    #1;
    if (r) begin
      exp_bubble = 0; exp_hold = 0; exp_flush = 0;
    end else if (f) exp_flush++;
    else if (se && !sm) exp_bubble++;
    else if (sm) exp_hold++;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                        input logic wh, input logic [31:0] hi, input logic [31:0] lo);
    ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat; ex_whilo = wh; ex_hi = hi; ex_lo = lo;
  endtask

  task automatic check_perf(input string tag);
    total++; if (perf_bubble !== (PERF ? 32'(exp_bubble) : 32'd0)) begin bad++;
      $display("FAIL %s perf_bubble got=%0d want=%0d", tag, perf_bubble, PERF ? exp_bubble : 0); end
    total++; if (perf_hold !== (PERF ? 32'(exp_hold) : 32'd0)) begin bad++;
      $display("FAIL %s perf_hold got=%0d want=%0d", tag, perf_hold, PERF ? exp_hold : 0); end
    total++; if (perf_flush !== (PERF ? 32'(exp_flush) : 32'd0)) begin bad++;
      $display("FAIL %s perf_flush got=%0d want=%0d", tag, perf_flush, PERF ? exp_flush : 0); end
  endtask

  task automatic test_reset;
    set_ex(1'b1, 5'd9, 1'b1, 32'hCAFE_0001, 1'b1, 32'h1, 32'h2);
    hilo_i = 64'h5; cnt_i = 2'd3;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} !== '0) begin
        bad++; $display("FAIL reset_mem cyc%0d got valid=%b wdata=%h", i, mem_valid, mem_wdata); end
      total++; if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
        bad++; $display("FAIL reset_scratch got hilo=%h cnt=%0d want 0", hilo_o, cnt_o); end
    end
    check_perf("reset");
    set_ex(1'b1, 5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (mem_valid !== 1'b1 || mem_wd !== 5'd3 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
      bad++; $display("FAIL load got v=%b wd=%0d wr=%b wdata=%h want 1 3 1 12345678",
                      mem_valid, mem_wd, mem_wreg, mem_wdata); end
  endtask

  task automatic test_hold;
    set_ex(1'b1, 5'd7, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    ex_wdata = 32'hFFFF_FFFF; ex_wd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      total++; if (mem_wdata !== 32'hA5A5_A5A5 || mem_wd !== 5'd7 || mem_valid !== 1'b1) begin
        bad++; $display("FAIL hold cyc%0d got wdata=%h wd=%0d want a5a5a5a5 7", i, mem_wdata, mem_wd); end
    end
    check_perf("hold");
  endtask

  task automatic test_bubble;
    set_ex(1'b1, 5'd4, 1'b1, 32'h7777_7777, 1'b1, 32'h8, 32'h9);
    hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (mem_valid !== 1'b0 || mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || mem_wdata !== 32'd0) begin
      bad++; $display("FAIL bubble_mem got v=%b wr=%b wh=%b wdata=%h want 0", mem_valid, mem_wreg, mem_whilo, mem_wdata); end
    total++; if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
      bad++; $display("FAIL bubble_scratch got hilo=%h cnt=%0d want 0000000100000002 1", hilo_o, cnt_o); end
    check_perf("bubble");
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (hilo_o !== 64'd0 || cnt_o !== 2'd0 || mem_wdata !== 32'h7777_7777) begin
      bad++; $display("FAIL bubble_then_load got hilo=%h cnt=%0d wdata=%h", hilo_o, cnt_o, mem_wdata); end
  endtask

  task automatic test_flush;
    hilo_i = 64'hAAAA_0000_0000_BBBB; cnt_i = 2'd2;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    set_ex(1'b1, 5'd12, 1'b1, 32'h3333_3333, 1'b1, 32'h4, 32'h5);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    total++; if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} !== '0) begin
      bad++; $display("FAIL flush_mem got v=%b wdata=%h want 0", mem_valid, mem_wdata); end
    total++; if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
      bad++; $display("FAIL flush_scratch got hilo=%h cnt=%0d want 0", hilo_o, cnt_o); end
    check_perf("flush");
  endtask

  task automatic test_gating;
    set_ex(1'b0, 5'd20, 1'b1, 32'h0101_0101, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (mem_wreg !== 1'b0 || mem_whilo !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL gate_off got wr=%b wh=%b v=%b want 0 0 0", mem_wreg, mem_whilo, mem_valid); end
    total++; if (mem_hi !== 32'hDEAD_BEEF || mem_lo !== 32'hCAFE_F00D || mem_wd !== 5'd20) begin
      bad++; $display("FAIL gate_fields got hi=%h lo=%h wd=%0d", mem_hi, mem_lo, mem_wd); end
    ex_valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (mem_whilo !== 1'b1 || mem_wreg !== 1'b1 || mem_valid !== 1'b1) begin
      bad++; $display("FAIL gate_on got wh=%b wr=%b v=%b want 1 1 1", mem_whilo, mem_wreg, mem_valid); end
  endtask

  task automatic test_illegal_stall;
    set_ex(1'b1, 5'd2, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 5'd30, 1'b0, 32'h2222_2222, 1'b1, 32'h6, 32'h7);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (mem_wdata !== 32'h1111_1111 || mem_wd !== 5'd2 || mem_wreg !== 1'b1 || mem_whilo !== 1'b0) begin
      bad++; $display("FAIL illegal_hold_mem got wdata=%h wd=%0d", mem_wdata, mem_wd); end
    hilo_i = 64'h0000_00FF_0000_00EE; cnt_i = 2'd3;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    hilo_i = 64'h1; cnt_i = 2'd0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (hilo_o !== 64'h0000_00FF_0000_00EE || cnt_o !== 2'd3) begin
      bad++; $display("FAIL illegal_hold_scratch got hilo=%h cnt=%0d want 000000ff000000ee 3", hilo_o, cnt_o); end
    check_perf("illegal");
  endtask

  task automatic test_reset_mid_op;
    hilo_i = 64'h1234; cnt_i = 2'd2;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
      bad++; $display("FAIL reset_mid_op got hilo=%h cnt=%0d want 0", hilo_o, cnt_o); end
    check_perf("reset_mid_op");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    hilo_i = 64'd0; cnt_i = 2'd0;
    test_reset();
    test_hold();
    test_bubble();
    test_flush();
    test_gating();
    test_illegal_stall();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
